// File: rtl/fpa_seq_ctrl.sv
// Multi-cycle single-precision floating-point adder sequencer: swap, align, add,
// iterative normalize (one shift per cycle), pack, then hold until the consumer accepts.
module fpa_seq_ctrl #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_sum,
  output logic [2:0]             out_flags,
  output logic                   busy,
  output logic [4:0]             cycles
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_PACK, S_HOLD} state_t;
  typedef enum logic [1:0] {K_NONE, K_NAN, K_INF, K_ZERO} kind_t;

  function automatic logic [EXP_W-1:0] f_eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

  // Truncating alignment: bits shifted past the LSB are simply dropped.
  function automatic logic [MAN_W:0] f_align(input logic [MAN_W:0] m, input logic [EXP_W-1:0] d);
    if (d >= EXP_W'(SW)) return '0;
    return m >> d;
  endfunction

  state_t               r_state, w_next;
  kind_t                r_kind, w_in_kind;
  logic [W-1:0]         r_x, r_y;
  logic [EXP_W-1:0]     r_er;
  logic [MAN_W:0]       r_mx, r_my, r_s;
  logic                 r_sub;
  logic [4:0]           r_cnt, r_cycles;
  logic [W-1:0]         r_sum, w_pack;
  logic [2:0]           r_flags, w_pack_flags;

  logic                 w_b_gt, w_x_nan, w_y_nan, w_x_inf, w_y_inf, w_norm_shift;
  logic [W-1:0]         w_x, w_y;
  logic [EXP_W-1:0]     w_ex, w_ey, w_d, w_er_inc;
  logic [SW-1:0]        w_sum;

  // Operand swap and special-value decode at accept
  assign w_b_gt  = in_b[W-2:0] > in_a[W-2:0];
  assign w_x     = w_b_gt ? in_b : in_a;
  assign w_y     = w_b_gt ? in_a : in_b;
  assign w_x_nan = (&w_x[W-2:MAN_W]) & (|w_x[MAN_W-1:0]);
  assign w_y_nan = (&w_y[W-2:MAN_W]) & (|w_y[MAN_W-1:0]);
  assign w_x_inf = (&w_x[W-2:MAN_W]) & ~(|w_x[MAN_W-1:0]);
  assign w_y_inf = (&w_y[W-2:MAN_W]) & ~(|w_y[MAN_W-1:0]);

  always_comb begin
    w_in_kind = K_NONE;
    if (w_x_nan || w_y_nan || (w_x_inf && w_y_inf && (w_x[W-1] != w_y[W-1])))
      w_in_kind = K_NAN;
    else if (w_x_inf || w_y_inf)
      w_in_kind = K_INF;
  end

  // Alignment and add/subtract of the latched operands
  assign w_ex     = f_eff_exp(r_x[W-2:MAN_W]);
  assign w_ey     = f_eff_exp(r_y[W-2:MAN_W]);
  assign w_d      = w_ex - w_ey;
  assign w_sum    = r_sub ? ({1'b0, r_mx} - {1'b0, r_my}) : ({1'b0, r_mx} + {1'b0, r_my});
  assign w_er_inc = r_er + EXP_W'(1);
  assign w_norm_shift = ~r_s[MAN_W] & (r_er > EXP_W'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = (w_in_kind != K_NONE) ? S_PACK : S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = (w_sum[SW-1:SW-2] == 2'b00 && w_sum != '0) ? S_NORM : S_PACK;
      // Leave NORM on the cycle whose shift sets the hidden bit or reaches ER==1
      S_NORM:  w_next = (w_norm_shift && !r_s[MAN_W-1] && r_er != EXP_W'(2)) ? S_NORM : S_PACK;
      S_PACK:  w_next = S_HOLD;
      S_HOLD:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pack       = {r_x[W-1], (r_s[MAN_W] ? r_er : EXP_W'(0)), r_s[MAN_W-1:0]};
    w_pack_flags = 3'b000;
    case (r_kind)
      K_NAN:  begin w_pack = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}}; w_pack_flags = 3'b100; end
      K_INF:  begin w_pack = {r_x[W-1], EMAX, {MAN_W{1'b0}}};       w_pack_flags = 3'b010; end
      K_ZERO: begin w_pack = {r_x[W-1], {(W-1){1'b0}}};             w_pack_flags = 3'b001; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: if (in_valid) begin
        r_x    <= w_x;
        r_y    <= w_y;
        r_kind <= w_in_kind;
      end
      S_ALIGN: begin
        r_er  <= w_ex;
        r_mx  <= {|r_x[W-2:MAN_W], r_x[MAN_W-1:0]};
        r_my  <= f_align({|r_y[W-2:MAN_W], r_y[MAN_W-1:0]}, w_d);
        r_sub <= r_x[W-1] ^ r_y[W-1];
      end
      S_ADD: begin
        if (w_sum == '0) begin
          r_kind <= K_ZERO;
        end else if (w_sum[SW-1]) begin
          r_s  <= w_sum[SW-1:1];
          r_er <= w_er_inc;
          if (w_er_inc == EMAX) r_kind <= K_INF;
        end else begin
          r_s <= w_sum[MAN_W:0];
        end
      end
      S_NORM: if (w_norm_shift) begin
        r_s  <= r_s << 1;
        r_er <= r_er - EXP_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_flags  <= '0;
      r_cycles <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE:                 if (in_valid) r_cnt <= 5'd1;
        S_ALIGN, S_ADD, S_NORM: r_cnt <= r_cnt + 5'd1;
        S_PACK: begin
          r_sum    <= w_pack;
          r_flags  <= w_pack_flags;
          r_cycles <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_HOLD);
  assign out_sum   = r_sum;
  assign out_flags = r_flags;
  assign cycles    = r_cycles;

endmodule

// File: tb/tb_fpa_seq_ctrl.sv
// Bench for fpa_seq_ctrl: directed cases, handshake stall, mid-operation reset,
// and randomized operands against an arithmetic reference model.
module tb_fpa_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, out_sum;
  logic [2:0]  out_flags;
  logic [4:0]  cycles;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  fpa_seq_ctrl #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_flags(out_flags), .busy(busy), .cycles(cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: integer mantissa arithmetic with truncation, counting normalize cycles.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] s, output logic [2:0] f, output int cyc);
    logic [31:0] x, y;
    int ex, ey, mx, my, d, er, k;
    longint sm;
    bit xnan, ynan, xinf, yinf;
    x = (b[30:0] > a[30:0]) ? b : a;
    y = (b[30:0] > a[30:0]) ? a : b;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    xnan = (ex == 255) && (x[22:0] != 0); ynan = (ey == 255) && (y[22:0] != 0);
    xinf = (ex == 255) && (x[22:0] == 0); yinf = (ey == 255) && (y[22:0] == 0);
    f = 3'b000; cyc = 2;
    if (xnan || ynan || (xinf && yinf && x[31] != y[31])) begin
      s = 32'h7FC00000; f = 3'b100; return;
    end
    if (xinf || yinf) begin
      s = {x[31], 8'hFF, 23'h0}; f = 3'b010; return;
    end
    mx = ((ex != 0) ? (1 << 23) : 0) + int'(x[22:0]);
    my = ((ey != 0) ? (1 << 23) : 0) + int'(y[22:0]);
    if (ex == 0) ex = 1;
    if (ey == 0) ey = 1;
    d  = ex - ey;
    my = (d >= 25) ? 0 : (my >> d);
    sm = (x[31] != y[31]) ? longint'(mx - my) : longint'(mx + my);
    er = ex; cyc = 4;
    if (sm == 0) begin
      s = {x[31], 31'h0}; f = 3'b001; return;
    end
    if (sm >= (64'd1 << 24)) begin
      sm = sm >> 1; er++;
      if (er == 255) begin s = {x[31], 8'hFF, 23'h0}; f = 3'b010; return; end
    end else if (sm < (64'd1 << 23)) begin
      k = 0;
      while (sm < (64'd1 << 23) && er > 1) begin sm = sm << 1; er--; k++; end
      cyc = 4 + ((k == 0) ? 1 : k);
    end
    s = {x[31], (sm >= (64'd1 << 23)) ? 8'(er) : 8'd0, 23'(sm)};
  endfunction

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic handshake(input int dly, input string tag);
    repeat (dly) @(negedge clk);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk({tag, "_ovld_after"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_after"},  32'(in_ready),  32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int dly, input string tag);
    logic [31:0] es; logic [2:0] ef; int ec, lat;
    ref_add(a, b, es, ef, ec);
    @(negedge clk); in_a = a; in_b = b; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(lat);
    chk({tag, "_latency"}, 32'(lat),       32'(ec));
    chk({tag, "_sum"},     out_sum,        es);
    chk({tag, "_flags"},   32'(out_flags), 32'(ef));
    chk({tag, "_cycles"},  32'(cycles),    32'(ec));
    handshake(dly, tag);
  endtask

  initial begin
    logic [31:0] a, b, es1, es2;
    logic [2:0]  ef1, ef2;
    int          ec1, ec2, lat, e, sel;
    bit          saw_valid;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_sum",   out_sum,        32'd0);
    chk("rst_flags",     32'(out_flags), 32'd0);
    chk("rst_cycles",    32'(cycles),    32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases with hand-derived expectations
    run_op(32'h461C4000, 32'hC5FA0000, 0, "d_10000m8000");
    chk("d1_sum_const", out_sum, 32'h44FA0000);
    chk("d1_cyc_const", 32'(cycles), 32'd7);
    run_op(32'hC5FA0000, 32'h45FA0000, 1, "d_cancel");
    chk("d2_sum_const", out_sum, 32'h80000000);
    chk("d2_flag_const", 32'(out_flags), 32'd1);
    run_op(32'h3F800000, 32'h3F800000, 0, "d_one_one");
    chk("d3_sum_const", out_sum, 32'h40000000);
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 0, "d_ovf");
    chk("d4_flag_const", 32'(out_flags), 32'd2);
    run_op(32'h7F800000, 32'h3F800000, 0, "d_inf");
    chk("d5_cyc_const", 32'(cycles), 32'd2);
    run_op(32'h7F800000, 32'hFF800000, 0, "d_inf_minf");
    chk("d6_sum_const", out_sum, 32'h7FC00000);
    run_op(32'h00000001, 32'h3FCA3D71, 0, "d_denorm");
    chk("d7_sum_const", out_sum, 32'h3FCA3D71);
    run_op(32'h7FC00001, 32'h3F800000, 0, "d_nan");
    run_op(32'h00400000, 32'h00400000, 0, "d_den_den");
    run_op(32'h00000003, 32'h80000001, 0, "d_den_sub");

    // Stall in HOLD with a second request pending
    ref_add(32'h3F800000, 32'h3F800000, es1, ef1, ec1);
    ref_add(32'h461C4000, 32'hC5FA0000, es2, ef2, ec2);
    @(negedge clk); in_a = 32'h3F800000; in_b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(lat);
    chk("stall_lat", 32'(lat), 32'(ec1));
    @(negedge clk); in_a = 32'h461C4000; in_b = 32'hC5FA0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_sum",  out_sum,        es1);
      chk("stall_ovld", 32'(out_valid), 32'd1);
      chk("stall_rdy",  32'(in_ready),  32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("stall_rdy_idle", 32'(in_ready), 32'd1);
    chk("stall_busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    chk("stall_2nd_busy", 32'(busy), 32'd1);
    wait_out(lat);
    chk("stall_2nd_lat", 32'(lat), 32'(ec2));
    chk("stall_2nd_sum", out_sum, es2);
    chk("stall_2nd_cyc", 32'(cycles), 32'(ec2));
    handshake(0, "stall_2nd");

    // Reset while normalizing
    @(negedge clk); in_a = 32'h461C4000; in_b = 32'hC5FA0000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovld", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy),      32'd0);
    chk("mid_rst_rdy",  32'(in_ready),  32'd1);
    chk("mid_rst_sum",  out_sum,        32'd0);
    chk("mid_rst_cyc",  32'(cycles),    32'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1 if (out_valid) saw_valid = 1'b1; end
    chk("mid_rst_no_result", 32'(saw_valid), 32'd0);
    run_op(32'h461C4000, 32'hC5FA0000, 0, "post_rst");

    // Randomized operands
    for (int n = 0; n < 300; n++) begin
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4, 5: begin
          e = int'(a[30:23]) + $urandom_range(0, 6) - 3;
          if (e < 0) e = 0;
          if (e > 254) e = 254;
          b = {1'($urandom), 8'(e), 23'($urandom)};
        end
        6: b = {~a[31], a[30:8], 8'($urandom)};
        7: b = {1'($urandom), 8'd0, 23'($urandom)};
        8: b = $urandom;
        default: b = {1'($urandom), 8'hFF, ($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
      endcase
      if ($urandom_range(0, 1) == 1) begin
        e = int'(b); b = a; a = 32'(e);
      end
      run_op(a, b, $urandom_range(0, 2), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpa_seq_ctrl.md
Name: fpa_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-precision floating-point add datapath: swap, align, add, normalize, pack, each step in its own FSM state.
- Normalization is iterative: one left shift per cycle.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Processes one operation at a time; no overlap between operations.

Parameters:
- EXP_W, 8, exponent width (IEEE single)
- MAN_W, 23, stored mantissa width (IEEE single)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept (high only in IDLE)
- in_a  in  32  operand A, IEEE-754 single
- in_b  in  32  operand B, IEEE-754 single
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  32  result, IEEE-754 single
- out_flags  out  3  {nan, inf, zero} for out_sum
- busy  out  1  high in any state except IDLE
- cycles  out  5  clock edges from accept to HOLD entry, for the last result

Behaviour:
- Reset (async, rst_n low): state=IDLE; out_valid=0, out_sum=0, out_flags=0, cycles=0, busy=0, in_ready=1 once out of reset. Reset mid-operation abandons the operation; no out_valid is produced for it.
- States: IDLE, ALIGN, ADD, NORM, PACK, HOLD.
- IDLE, accept on in_valid&in_ready:
  - Latch the larger magnitude (compare [30:0]) as X, the other as Y. On a tie, X=in_a.
  - Decode specials:
    - Either operand NaN (E=255, M!=0) -> NaN result.
    - inf + opposite-sign inf -> NaN result.
    - Otherwise any inf -> inf with that inf's sign.
  - Special -> PACK. Otherwise -> ALIGN.
  - in_valid while busy is ignored; the source holds it.
- ALIGN:
  - Effective exponent e'=(E==0)?1:E.
  - Hidden bit = |E.
  - d = e'X - e'Y.
  - MY = {hid, M_Y} >> d; d>=25 gives MY=0.
  - sub = SX^SY.
  - -> ADD.
- ADD:
  - 25-bit S = {hidX, M_X} ± MY.
  - Exponent register ER = e'X.
  - S==0 -> zero result, sign SX -> PACK.
  - S[24]=1 -> S>>1, ER+1. If ER+1==255 -> inf result, sign SX. -> PACK.
  - S[23]=1 -> PACK.
  - Otherwise -> NORM.
- NORM, each cycle:
  - If S[23]=0 and ER>1: S<<1, ER-1, stay in NORM.
  - Exit to PACK when S[23]=1 or ER==1.
  - ER==1 with S[23]=0 -> denormal, stored exponent 0.
  - At most 23 cycles.
- PACK:
  - Normal: out_sum={SX, ER, S[22:0]}.
  - NaN: 0x7FC00000, flag nan.
  - inf: {sign, 8'hFF, 0}, flag inf.
  - zero: {SX, 31'b0}, flag zero.
  - Latch cycles. -> HOLD.
- HOLD:
  - out_valid=1; out_sum/out_flags stable until out_valid&out_ready.
  - On handshake -> IDLE.
  - out_ready is sampled only in HOLD.
- Rounding: truncation. Guard bits shifted out are discarded.
- Latency (edges from accept to out_valid):
  - 4+n for finite results, n = NORM cycles.
  - 2 for specials.
  - Next accept is no earlier than the edge after the out handshake.

Test Plan:
- 0x461C4000 (10000) + 0xC5FA0000 (-8000) -> out_sum=0x44FA0000, flags=000, cycles=7 (n=3).
- 0xC5FA0000 + 0x45FA0000 -> out_sum=0x80000000, flags=001, cycles=4.
- 0x3F800000 + 0x3F800000 -> 0x40000000, cycles=4.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags=010.
- 0x7F800000 + 0x3F800000 -> 0x7F800000, flags=010, cycles=2.
- 0x7F800000 + 0xFF800000 -> 0x7FC00000, flags=100.
- 0x00000001 + 0x3FCA3D71 -> 0x3FCA3D71 (denormal absorbed by truncation), cycles=4.
- out_ready low 5 cycles in HOLD -> out_sum stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
- rst_n pulsed low during NORM of case 1 -> out_valid=0, busy=0 immediately, state=IDLE; the next operation completes correctly.
